// File: rtl/interrupt_ack_sequencer_8259.sv
// 8259A INTA# cycle sequencer: synchronizes INTA#, steps through the acknowledge
// pulses, latches the serviced level and drives CALL/vector bytes and cascade ID.
module interrupt_ack_sequencer_8259 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        interrupt_acknowledge_n,
  input  logic        write_initial_command_word_1,
  input  logic        mode_8086,
  input  logic        call_address_interval_4,
  input  logic        auto_eoi_config,
  input  logic        single_or_cascade_config,
  input  logic        slave_program_n,
  input  logic [7:0]  cascade_device_config,
  input  logic [10:0] interrupt_vector_address,
  input  logic [2:0]  cascade_in,
  input  logic        interrupt_request_valid,
  input  logic [2:0]  interrupt_level,
  output logic        freeze,
  output logic        latch_in_service,
  output logic [2:0]  latched_level,
  output logic        end_of_interrupt_auto,
  output logic        out_data_valid,
  output logic [7:0]  out_data,
  output logic [2:0]  cascade_out,
  output logic        cascade_drive_en
);

  typedef enum logic [1:0] {S_IDLE, S_ACK1, S_ACK2, S_ACK3} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_inta_sync;
  logic                   r_inta_prev;
  logic                   r_mode_8086;
  logic                   r_spurious;
  logic                   r_cas_master;

  logic       w_inta;
  logic       w_fall;
  logic       w_rise;
  logic [2:0] w_first_level;
  logic       w_master_hit;
  logic       w_slave_hit;
  logic       w_drive_vec;
  logic       w_drive_call;
  logic [7:0] w_byte2_mcs;
  logic [7:0] w_byte2_8086;

  assign w_inta = r_inta_sync[SYNC_STAGES-1];
  assign w_fall = r_inta_prev & ~w_inta;
  assign w_rise = ~r_inta_prev & w_inta;

  assign w_first_level = interrupt_request_valid ? interrupt_level : 3'd7;
  assign w_master_hit  = ~single_or_cascade_config & slave_program_n
                         & cascade_device_config[w_first_level];
  assign w_slave_hit   = ~single_or_cascade_config & ~slave_program_n
                         & (cascade_in == cascade_device_config[2:0]);

  // A master that handed the cycle to a slave stays off the bus after the CALL byte.
  assign w_drive_vec  = single_or_cascade_config
                        | (slave_program_n ? ~r_cas_master : w_slave_hit);
  // The CALL opcode always comes from the master (or a single device), never a slave.
  assign w_drive_call = single_or_cascade_config | slave_program_n;

  assign w_byte2_mcs  = call_address_interval_4
                        ? {interrupt_vector_address[2:0], r_inta_level_unused_fix(latched_level), 2'b00}
                        : {interrupt_vector_address[2:1], latched_level, 3'b000};
  assign w_byte2_8086 = {interrupt_vector_address[10:6], latched_level};

  function automatic logic [2:0] r_inta_level_unused_fix(input logic [2:0] lvl);
    return lvl;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_inta_sync           <= '1;
      r_inta_prev           <= 1'b1;
      r_state               <= S_IDLE;
      r_mode_8086           <= 1'b0;
      r_spurious            <= 1'b0;
      r_cas_master          <= 1'b0;
      freeze                <= 1'b0;
      latch_in_service      <= 1'b0;
      latched_level         <= 3'd0;
      end_of_interrupt_auto <= 1'b0;
      out_data_valid        <= 1'b0;
      out_data              <= 8'h00;
      cascade_out           <= 3'd0;
      cascade_drive_en      <= 1'b0;
    end else begin
      r_inta_sync           <= {r_inta_sync[SYNC_STAGES-2:0], interrupt_acknowledge_n};
      r_inta_prev           <= w_inta;
      latch_in_service      <= 1'b0;
      end_of_interrupt_auto <= 1'b0;

      if (write_initial_command_word_1) begin
        r_state          <= S_IDLE;
        r_mode_8086      <= 1'b0;
        r_spurious       <= 1'b0;
        r_cas_master     <= 1'b0;
        freeze           <= 1'b0;
        latched_level    <= 3'd0;
        out_data_valid   <= 1'b0;
        out_data         <= 8'h00;
        cascade_out      <= 3'd0;
        cascade_drive_en <= 1'b0;
      end else if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            r_state          <= S_ACK1;
            freeze           <= 1'b1;
            latched_level    <= w_first_level;
            latch_in_service <= interrupt_request_valid;
            r_spurious       <= ~interrupt_request_valid;
            r_mode_8086      <= mode_8086;
            r_cas_master     <= w_master_hit;
            cascade_drive_en <= w_master_hit;
            cascade_out      <= w_master_hit ? w_first_level : 3'd0;
            out_data_valid   <= ~mode_8086 & w_drive_call;
            out_data         <= (~mode_8086 & w_drive_call) ? 8'hCD : 8'h00;
          end
          S_ACK1: begin
            r_state        <= S_ACK2;
            out_data_valid <= w_drive_vec;
            out_data       <= w_drive_vec ? (r_mode_8086 ? w_byte2_8086 : w_byte2_mcs) : 8'h00;
          end
          S_ACK2: begin
            if (!r_mode_8086) begin
              r_state        <= S_ACK3;
              out_data_valid <= w_drive_vec;
              out_data       <= w_drive_vec ? interrupt_vector_address[10:3] : 8'h00;
            end else begin
              out_data_valid <= 1'b0;
              out_data       <= 8'h00;
            end
          end
          default: begin
            out_data_valid <= 1'b0;
            out_data       <= 8'h00;
          end
        endcase
      end else if (w_rise) begin
        out_data_valid <= 1'b0;
        out_data       <= 8'h00;
        if ((r_state == S_ACK3 && !r_mode_8086) || (r_state == S_ACK2 && r_mode_8086)) begin
          r_state               <= S_IDLE;
          freeze                <= 1'b0;
          cascade_drive_en      <= 1'b0;
          cascade_out           <= 3'd0;
          r_cas_master          <= 1'b0;
          end_of_interrupt_auto <= auto_eoi_config & ~r_spurious;
        end
      end
    end
  end

endmodule

// File: tb/tb_interrupt_ack_sequencer_8259.sv
// Directed bench for interrupt_ack_sequencer_8259: table of full INTA sequences
// plus hand sequences for reset/ICW1 abort and mode hold.
module tb_interrupt_ack_sequencer_8259;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        interrupt_acknowledge_n;
  logic        write_initial_command_word_1;
  logic        mode_8086;
  logic        call_address_interval_4;
  logic        auto_eoi_config;
  logic        single_or_cascade_config;
  logic        slave_program_n;
  logic [7:0]  cascade_device_config;
  logic [10:0] interrupt_vector_address;
  logic [2:0]  cascade_in;
  logic        interrupt_request_valid;
  logic [2:0]  interrupt_level;
  logic        freeze;
  logic        latch_in_service;
  logic [2:0]  latched_level;
  logic        end_of_interrupt_auto;
  logic        out_data_valid;
  logic [7:0]  out_data;
  logic [2:0]  cascade_out;
  logic        cascade_drive_en;

  int total = 0;
  int bad   = 0;

  interrupt_ack_sequencer_8259 #(.SYNC_STAGES(2)) dut (
    .clock                        (clock),
    .reset_n                      (reset_n),
    .interrupt_acknowledge_n      (interrupt_acknowledge_n),
    .write_initial_command_word_1 (write_initial_command_word_1),
    .mode_8086                    (mode_8086),
    .call_address_interval_4      (call_address_interval_4),
    .auto_eoi_config              (auto_eoi_config),
    .single_or_cascade_config     (single_or_cascade_config),
    .slave_program_n              (slave_program_n),
    .cascade_device_config        (cascade_device_config),
    .interrupt_vector_address     (interrupt_vector_address),
    .cascade_in                   (cascade_in),
    .interrupt_request_valid      (interrupt_request_valid),
    .interrupt_level              (interrupt_level),
    .freeze                       (freeze),
    .latch_in_service             (latch_in_service),
    .latched_level                (latched_level),
    .end_of_interrupt_auto        (end_of_interrupt_auto),
    .out_data_valid               (out_data_valid),
    .out_data                     (out_data),
    .cascade_out                  (cascade_out),
    .cascade_drive_en             (cascade_drive_en)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        m86, adi, aeoi, sngl, spn;
    logic [7:0]  cfg;
    logic [10:0] vec;
    logic [2:0]  cin;
    logic        rv;
    logic [2:0]  lvl;
    int          np;
    logic [2:0]  ev;     // expected out_data_valid per pulse
    logic [23:0] ed;     // expected byte per pulse, pulse 0 in [7:0]
    logic        elis;
    logic [2:0]  ell;
    logic        eeoi;
    logic        ecde;
    logic [2:0]  ecout;
  } seq_t;

  seq_t tv [9];

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s seq=%0d actual=%0h required=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply_cfg(input seq_t v);
    @(negedge clock);
    mode_8086                = v.m86;
    call_address_interval_4  = v.adi;
    auto_eoi_config          = v.aeoi;
    single_or_cascade_config = v.sngl;
    slave_program_n          = v.spn;
    cascade_device_config    = v.cfg;
    interrupt_vector_address = v.vec;
    cascade_in               = v.cin;
    interrupt_request_valid  = v.rv;
    interrupt_level          = v.lvl;
  endtask

  task automatic fall_pin();
    @(negedge clock);
    interrupt_acknowledge_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic rise_pin();
    @(negedge clock);
    interrupt_acknowledge_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic run_seq(input int idx, input seq_t v);
    apply_cfg(v);
    for (int p = 0; p < v.np; p++) begin
      fall_pin();
      check("freeze_at_fall", idx, 32'(freeze), 32'd1);
      check("data_valid", idx, 32'(out_data_valid), 32'(v.ev[p]));
      if (v.ev[p]) check("data_byte", idx, 32'(out_data), 32'(v.ed[p*8 +: 8]));
      check("cas_drive_en", idx, 32'(cascade_drive_en), 32'(v.ecde));
      check("cas_out", idx, 32'(cascade_out), 32'(v.ecout));
      if (p == 0) begin
        check("latch_is", idx, 32'(latch_in_service), 32'(v.elis));
        check("latched_level", idx, 32'(latched_level), 32'(v.ell));
        // the resolver moves on; the sequence must keep the captured level
        interrupt_level         = ~v.lvl;
        interrupt_request_valid = 1'b1;
        @(posedge clock); #1;
        check("latch_is_width", idx, 32'(latch_in_service), 32'd0);
      end
      rise_pin();
      check("valid_at_rise", idx, 32'(out_data_valid), 32'd0);
      if (p == v.np - 1) begin
        check("freeze_end", idx, 32'(freeze), 32'd0);
        check("cas_drive_end", idx, 32'(cascade_drive_en), 32'd0);
        check("eoi_pulse", idx, 32'(end_of_interrupt_auto), 32'(v.eeoi));
        check("level_at_end", idx, 32'(latched_level), 32'(v.ell));
        @(posedge clock); #1;
        check("eoi_width", idx, 32'(end_of_interrupt_auto), 32'd0);
      end else begin
        check("freeze_mid", idx, 32'(freeze), 32'd1);
        check("eoi_mid", idx, 32'(end_of_interrupt_auto), 32'd0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    //         m86  adi  aeoi sngl spn  cfg    vec      cin  rv   lvl  np ev      ed          elis ell  eeoi ecde ecout
    tv[0] = '{1'b0,1'b1,1'b0,1'b1,1'b1,8'h00,11'h7FF,3'd0,1'b1,3'd1,3,3'b111,24'hFFE4CD,1'b1,3'd1,1'b0,1'b0,3'd0};
    tv[1] = '{1'b1,1'b0,1'b1,1'b1,1'b1,8'h00,11'h7C0,3'd0,1'b1,3'd0,2,3'b010,24'h00F800,1'b1,3'd0,1'b1,1'b0,3'd0};
    tv[2] = '{1'b0,1'b1,1'b0,1'b0,1'b1,8'hFF,11'h7FF,3'd0,1'b1,3'd0,3,3'b001,24'h0000CD,1'b1,3'd0,1'b0,1'b1,3'd0};
    tv[3] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h03,11'h200,3'd3,1'b1,3'd5,2,3'b010,24'h004500,1'b1,3'd5,1'b0,1'b0,3'd0};
    tv[4] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h03,11'h200,3'd2,1'b1,3'd5,2,3'b000,24'h000000,1'b1,3'd5,1'b0,1'b0,3'd0};
    tv[5] = '{1'b0,1'b1,1'b1,1'b1,1'b1,8'h00,11'h102,3'd0,1'b0,3'd2,3,3'b111,24'h205CCD,1'b0,3'd7,1'b0,1'b0,3'd0};
    tv[6] = '{1'b0,1'b0,1'b1,1'b1,1'b1,8'h00,11'h4D6,3'd0,1'b1,3'd3,3,3'b111,24'h9AD8CD,1'b1,3'd3,1'b1,1'b0,3'd0};
    tv[7] = '{1'b0,1'b1,1'b0,1'b0,1'b1,8'h04,11'h081,3'd0,1'b1,3'd1,3,3'b111,24'h1024CD,1'b1,3'd1,1'b0,1'b0,3'd0};
    tv[8] = '{1'b0,1'b0,1'b1,1'b0,1'b1,8'h40,11'h7FF,3'd0,1'b1,3'd6,3,3'b001,24'h0000CD,1'b1,3'd6,1'b1,1'b1,3'd6};

    reset_n                      = 1'b0;
    interrupt_acknowledge_n      = 1'b1;
    write_initial_command_word_1 = 1'b0;
    mode_8086                    = 1'b0;
    call_address_interval_4      = 1'b0;
    auto_eoi_config              = 1'b0;
    single_or_cascade_config     = 1'b1;
    slave_program_n              = 1'b1;
    cascade_device_config        = 8'h00;
    interrupt_vector_address     = 11'h000;
    cascade_in                   = 3'd0;
    interrupt_request_valid      = 1'b0;
    interrupt_level              = 3'd0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_outputs", -1,
          {18'd0, freeze, latch_in_service, latched_level, end_of_interrupt_auto,
           out_data_valid, cascade_drive_en, cascade_out, 3'd0},
          32'd0);
    check("rst_data", -1, 32'(out_data), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    for (int i = 0; i < 9; i++) run_seq(i, tv[i]);

    // async reset between pulses 1 and 2 of a cascade-master sequence
    apply_cfg(tv[2]);
    fall_pin();
    check("pre_rst_cde", 100, 32'(cascade_drive_en), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_freeze", 100, 32'(freeze), 32'd0);
    check("rst_cde", 100, 32'(cascade_drive_en), 32'd0);
    check("rst_valid", 100, 32'(out_data_valid), 32'd0);
    check("rst_level", 100, 32'(latched_level), 32'd0);
    interrupt_acknowledge_n = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    run_seq(101, tv[0]);

    // ICW1 strobe between pulses 1 and 2 aborts without latch/EOI
    apply_cfg(tv[8]);
    fall_pin();
    check("pre_icw1_cout", 200, 32'(cascade_out), 32'd6);
    @(negedge clock);
    write_initial_command_word_1 = 1'b1;
    @(posedge clock); #1;
    check("icw1_freeze", 200, 32'(freeze), 32'd0);
    check("icw1_cde", 200, 32'(cascade_drive_en), 32'd0);
    check("icw1_cout", 200, 32'(cascade_out), 32'd0);
    check("icw1_valid", 200, 32'(out_data_valid), 32'd0);
    check("icw1_lis", 200, 32'(latch_in_service), 32'd0);
    @(negedge clock);
    write_initial_command_word_1 = 1'b0;
    rise_pin();
    check("icw1_eoi", 200, 32'(end_of_interrupt_auto), 32'd0);
    check("icw1_freeze_after", 200, 32'(freeze), 32'd0);
    run_seq(201, tv[1]);

    // mode_8086 flips after the first fall: sequence stays MCS-80 (3 pulses)
    apply_cfg(tv[0]);
    fall_pin();
    check("mode_byte1", 300, 32'(out_data), 32'hCD);
    rise_pin();
    mode_8086 = 1'b1;
    fall_pin();
    check("mode_byte2", 300, 32'(out_data), 32'hE4);
    rise_pin();
    check("mode_freeze2", 300, 32'(freeze), 32'd1);
    fall_pin();
    check("mode_byte3", 300, 32'(out_data), 32'hFF);
    rise_pin();
    check("mode_freeze3", 300, 32'(freeze), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
